// File: rtl/up_counter_8b.sv
// WIDTH-bit binary up-counter with synchronous parallel load, count enable
// and asynchronous active-low clear; COUNT comes straight from the register.
`timescale 1ns/1ps

module up_counter_8b #(
    parameter int WIDTH = 8
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] DATA,
    output logic [WIDTH-1:0] COUNT
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Load wins over enable; the increment wraps naturally modulo 2^WIDTH.
    always_comb begin
        count_d = count_q;
        if (LOAD) begin
            count_d = DATA;
        end else if (ENABLE) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign COUNT = count_q;

endmodule

// File: tb/tb_up_counter_8b.sv
// Directed bench for up_counter_8b: reset, counting, load priority,
// wrap-around, asynchronous clear and held load.
`timescale 1ns/1ps

module tb_up_counter_8b;

    logic       CLOCK;
    logic       RESET;
    logic       ENABLE;
    logic       LOAD;
    logic [7:0] DATA;
    logic [7:0] COUNT;

    int passed;
    int total;

    up_counter_8b #(.WIDTH(8)) dut (
        .CLOCK  (CLOCK),
        .RESET  (RESET),
        .ENABLE (ENABLE),
        .LOAD   (LOAD),
        .DATA   (DATA),
        .COUNT  (COUNT)
    );

    initial CLOCK = 1'b0;
    always #10 CLOCK = ~CLOCK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, sample 1ns later, compare.
    task automatic step(input string tag, input logic [7:0] exp);
        @(posedge CLOCK);
        #1;
        chk(tag, COUNT, exp);
    endtask

    initial begin
        passed = 0;
        total  = 0;

        // Power-up reset, released at 1ns; first edge at 10ns.
        RESET  = 1'b0;
        ENABLE = 1'b1;
        LOAD   = 1'b0;
        DATA   = 8'd0;
        #0.5;
        chk("reset_before_release", COUNT, 8'd0);
        #0.5;
        RESET = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step($sformatf("count_after_reset_%0d", i), 8'(i));
        end

        // Parallel load mid-count, then continue through wrap-around.
        LOAD = 1'b1;
        DATA = 8'd240;
        step("load_240", 8'd240);
        LOAD = 1'b0;
        DATA = 8'd0;
        for (int v = 241; v <= 255; v++) begin
            step($sformatf("count_%0d", v), 8'(v));
        end
        step("wrap_to_0", 8'd0);
        step("after_wrap_1", 8'd1);

        // Load 37 with ENABLE=1, then hold with ENABLE=0.
        LOAD = 1'b1;
        DATA = 8'd37;
        step("load_37", 8'd37);
        LOAD   = 1'b0;
        ENABLE = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step($sformatf("hold_37_edge%0d", i), 8'd37);
        end

        // Load priority regardless of ENABLE.
        LOAD = 1'b1;
        DATA = 8'd100;
        step("load_100_en0", 8'd100);
        ENABLE = 1'b1;
        DATA   = 8'd50;
        step("load_50_en1", 8'd50);

        // Inputs pulsed between edges must have no effect.
        LOAD = 1'b0;
        #3;
        LOAD = 1'b1;
        DATA = 8'd99;
        #3;
        LOAD = 1'b0;
        DATA = 8'd0;
        step("between_edge_pulse", 8'd51);

        // Asynchronous reset mid-cycle at COUNT=200.
        LOAD   = 1'b1;
        DATA   = 8'd200;
        step("load_200", 8'd200);
        LOAD   = 1'b0;
        ENABLE = 1'b0;
        #5;
        RESET = 1'b0;
        #1;
        chk("async_clear_immediate", COUNT, 8'd0);
        LOAD   = 1'b1;
        DATA   = 8'd77;
        ENABLE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step($sformatf("held_in_reset_%0d", i), 8'd0);
        end
        LOAD = 1'b0;
        DATA = 8'd0;
        #5;
        RESET = 1'b1;
        step("resume_1", 8'd1);
        step("resume_2", 8'd2);

        // LOAD held high freezes COUNT at DATA.
        LOAD = 1'b1;
        DATA = 8'd10;
        for (int i = 0; i < 4; i++) begin
            step($sformatf("load_held_%0d", i), 8'd10);
        end
        LOAD = 1'b0;
        step("after_held_load", 8'd11);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/up_counter_8b.md
Name: up_counter_8b

Overview:
- Synchronous 8-bit binary up-counter with parallel load, count enable and asynchronous clear.
- General-purpose sequencing and timing element.
- Single clock domain.
- Registered output; no combinational paths from inputs to COUNT.

Parameters:
- WIDTH, 8, counter and load-data width in bits. All widths below are in terms of WIDTH; the default of 8 is the verified configuration.

Ports:
- CLOCK  input  1  system clock; all state changes on the rising edge except reset.
- RESET  input  1  asynchronous, active-low reset; 0 clears the counter.
- ENABLE  input  1  count enable; 1 increments on the rising edge.
- LOAD  input  1  synchronous parallel-load strobe, active-high.
- DATA  input  WIDTH  parallel-load value.
- COUNT  output  WIDTH  current counter value, driven directly from the state register.

Interface decisions (already decided):
- One clock, CLOCK.
- Reset RESET is asynchronous and active-low.

Behaviour:
- Reset:
  - RESET=0 forces COUNT=0 immediately, without waiting for a clock edge.
  - COUNT holds 0 for as long as RESET=0, regardless of CLOCK, ENABLE, LOAD or DATA.
  - Reset asserted mid-count clears at once; any pending load or increment is discarded.
- Reset release:
  - After RESET returns to 1, the first rising CLOCK edge is evaluated normally.
  - No extra synchronisation latency.
- Priority on each rising CLOCK edge with RESET=1, highest first:
  1. LOAD=1: COUNT <= DATA. Applies whether ENABLE is 0 or 1.
  2. LOAD=0, ENABLE=1: COUNT <= COUNT + 1, modulo 2^WIDTH.
  3. LOAD=0, ENABLE=0: COUNT holds.
- Latency:
  - A load or increment is visible on COUNT one clock edge after the controlling inputs are sampled.
  - COUNT changes only on rising edges, except for asynchronous reset.
- Wrap-around: COUNT=255 (all ones) with ENABLE=1 and LOAD=0 goes to 0 on the next edge. No saturation, no carry output.
- Load held high: LOAD=1 over several consecutive edges reloads DATA on every edge, so COUNT is frozen at DATA while LOAD stays high.
- Counting after load:
  - The first edge with LOAD=0 and ENABLE=1 following a load yields DATA+1.
  - Loading 255 and then counting gives 0 on the next enabled edge.
- Input timing: DATA, LOAD and ENABLE are sampled only at rising edges. Changes between edges have no effect.
- Implementation: one WIDTH-bit register, no latches, no gated clocks, no X on COUNT once reset has been applied.

Test Plan:
- Power-up reset: RESET=0 at t=0 with ENABLE=1, LOAD=0, DATA=0, released at t=1ns; 20ns clock, first rising edge at 10ns -> COUNT=0 before release, then 1,2,3,… on successive edges, reaching 8 on the 8th edge (150ns).
- Parallel load mid-count: at COUNT=8, assert LOAD=1 with DATA=240 across one edge, then LOAD=0, DATA=0 -> COUNT=240 after that edge, then 241, 242, … each edge; DATA=0 after the load has no effect.
- Wrap-around: continue counting from 240 -> 255 followed by 0, then 1, with no glitch or stall.
- Enable hold and load priority:
  - ENABLE=0 at COUNT=37 for 5 edges -> COUNT stays 37.
  - LOAD=1, DATA=100 with ENABLE=0 -> COUNT=100.
  - LOAD=1, DATA=50 with ENABLE=1 -> COUNT=50, not 51.
- Asynchronous reset mid-operation: drive RESET=0 between clock edges while COUNT=200 -> COUNT=0 immediately, before the next edge. It stays 0 across edges while RESET=0 even with LOAD=1, DATA=77, and resumes 1,2,… after release.
- LOAD held: LOAD=1, DATA=10 for 4 edges with ENABLE=1 -> COUNT=10 on all 4. On the first edge after LOAD drops, COUNT=11.
